// File: rtl/cond_pkg.sv
// cond_pkg: shared definitions for the conditional-execution stage.
//   cond_e     : the 16 instruction condition codes (Cond[31:28]).
//   FLG_*      : bit positions of V, C, N, Z inside the 4-bit flag vector.
//   FLAGW_*    : bit positions of the two independent flag-write requests.
package cond_pkg;

  typedef enum logic [3:0] {
    CondEq = 4'b0000,
    CondNe = 4'b0001,
    CondCs = 4'b0010,
    CondCc = 4'b0011,
    CondMi = 4'b0100,
    CondPl = 4'b0101,
    CondVs = 4'b0110,
    CondVc = 4'b0111,
    CondHi = 4'b1000,
    CondLs = 4'b1001,
    CondGe = 4'b1010,
    CondLt = 4'b1011,
    CondGt = 4'b1100,
    CondLe = 4'b1101,
    CondAl = 4'b1110,
    CondNv = 4'b1111
  } cond_e;

  localparam int unsigned FLG_V = 3;
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_N = 1;
  localparam int unsigned FLG_Z = 0;

  localparam int unsigned FLAGW_NZ = 1;
  localparam int unsigned FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// cond_check: purely combinational condition evaluator.
// Ports:
//   Cond   in  4  instruction condition field
//   Flags  in  4  stored flags, [3]=V [2]=C [1]=N [0]=Z
//   CondEx out 1  condition passed
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic flg_n, flg_z, flg_c, flg_v;
  logic ge;

  assign flg_n = Flags[FLG_N];
  assign flg_z = Flags[FLG_Z];
  assign flg_c = Flags[FLG_C];
  assign flg_v = Flags[FLG_V];
  assign ge    = (flg_n == flg_v);

  always_comb begin
    CondEx = 1'b1;
    unique case (cond_e'(Cond))
      CondEq: CondEx = flg_z;
      CondNe: CondEx = ~flg_z;
      CondCs: CondEx = flg_c;
      CondCc: CondEx = ~flg_c;
      CondMi: CondEx = flg_n;
      CondPl: CondEx = ~flg_n;
      CondVs: CondEx = flg_v;
      CondVc: CondEx = ~flg_v;
      CondHi: CondEx = flg_c & ~flg_z;
      CondLs: CondEx = ~flg_c | flg_z;
      CondGe: CondEx = ge;
      CondLt: CondEx = ~ge;
      CondGt: CondEx = ~flg_z & ge;
      CondLe: CondEx = flg_z | ~ge;
      CondAl: CondEx = 1'b1;
      // The never-code is executed unconditionally, same as AL.
      CondNv: CondEx = 1'b1;
      default: CondEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_logic_unit.sv
// cond_logic_unit: conditional-execution stage after the ALU.
// Holds the NZCV flag register, evaluates the condition field against the
// stored flags and gates the decoder strobes.
// Optional feature macro: COND_PERF_CNT_EN (enables exec/squash counters;
// when undefined the counters read 0 and perf_clr is ignored).
// Ports:
//   clk, rst_n (synchronous, active-low)
//   instr_valid, Cond[3:0], ALUFlags[3:0], FlagW[1:0], PCS, RegW, MemW,
//   NoWrite, perf_clr                                          -- inputs
//   CondEx, PCSrc, RegWrite, MemWrite, Flags[3:0],
//   exec_cnt[CNT_W-1:0], squash_cnt[CNT_W-1:0]                -- outputs
module cond_logic_unit
  import cond_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             perf_clr,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  logic [3:0] flags_q;
  logic       fire;
  logic       nz_we;
  logic       cv_we;

  // Evaluation always uses the registered flags, never same-cycle ALUFlags.
  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (flags_q),
    .CondEx (CondEx)
  );

  assign fire     = CondEx & instr_valid;
  assign PCSrc    = PCS & fire;
  assign RegWrite = RegW & ~NoWrite & fire;
  assign MemWrite = MemW & fire;
  assign Flags    = flags_q;

  assign nz_we = FlagW[FLAGW_NZ] & fire;
  assign cv_we = FlagW[FLAGW_CV] & fire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else begin
      if (nz_we) begin
        flags_q[FLG_N] <= ALUFlags[FLG_N];
        flags_q[FLG_Z] <= ALUFlags[FLG_Z];
      end
      if (cv_we) begin
        flags_q[FLG_C] <= ALUFlags[FLG_C];
        flags_q[FLG_V] <= ALUFlags[FLG_V];
      end
    end
  end

`ifdef COND_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] exec_q;
  logic [CNT_W-1:0] squash_q;

  // Each valid instruction bumps exactly one counter; both saturate.
  always_ff @(posedge clk) begin
    if (!rst_n || perf_clr) begin
      exec_q   <= '0;
      squash_q <= '0;
    end else if (instr_valid) begin
      if (CondEx) begin
        if (exec_q != CntMax) exec_q <= exec_q + CNT_W'(1);
      end else begin
        if (squash_q != CntMax) squash_q <= squash_q + CNT_W'(1);
      end
    end
  end

  assign exec_cnt   = exec_q;
  assign squash_cnt = squash_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign exec_cnt        = '0;
  assign squash_cnt      = '0;
`endif

endmodule

// File: tb/tb_cond_logic_unit.sv
module tb_cond_logic_unit;

`ifdef COND_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic [3:0]    Cond;
  logic [3:0]    ALUFlags;
  logic [1:0]    FlagW;
  logic          PCS, RegW, MemW, NoWrite, perf_clr;
  logic          CondEx, PCSrc, RegWrite, MemWrite;
  logic [3:0]    Flags;
  logic [CW-1:0] exec_cnt, squash_cnt;

  int checks = 0;
  int errors = 0;
  int exp_exec = 0;
  int exp_squash = 0;

  always #5 clk = ~clk;

  cond_logic_unit #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .Cond        (Cond),
    .ALUFlags    (ALUFlags),
    .FlagW       (FlagW),
    .PCS         (PCS),
    .RegW        (RegW),
    .MemW        (MemW),
    .NoWrite     (NoWrite),
    .perf_clr    (perf_clr),
    .CondEx      (CondEx),
    .PCSrc       (PCSrc),
    .RegWrite    (RegWrite),
    .MemWrite    (MemWrite),
    .Flags       (Flags),
    .exec_cnt    (exec_cnt),
    .squash_cnt  (squash_cnt)
  );

  typedef struct {
    string      name;
    logic       valid;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] flagw;
    logic       pcs, regw, memw, nowr;
    logic       e_cx, e_pc, e_rw, e_mw;
    logic [3:0] e_flags;  // flags after the clock edge
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic v, logic [3:0] c, logic [3:0] a, logic [1:0] fw,
                              logic pc, logic rw, logic mw, logic nw, logic ecx, logic epc,
                              logic erw, logic emw, logic [3:0] ef);
    vec_t t;
    t.name = n; t.valid = v; t.cond = c; t.alu = a; t.flagw = fw;
    t.pcs = pc; t.regw = rw; t.memw = mw; t.nowr = nw;
    t.e_cx = ecx; t.e_pc = epc; t.e_rw = erw; t.e_mw = emw; t.e_flags = ef;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int sat(int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic chk_cnt(string name);
    chk({name, ".exec"}, 32'(exec_cnt), PerfEn ? 32'(exp_exec) : 32'd0);
    chk({name, ".squash"}, 32'(squash_cnt), PerfEn ? 32'(exp_squash) : 32'd0);
  endtask

  task automatic drive(logic v, logic [3:0] c, logic [3:0] a, logic [1:0] fw,
                       logic pc, logic rw, logic mw, logic nw);
    instr_valid = v; Cond = c; ALUFlags = a; FlagW = fw;
    PCS = pc; RegW = rw; MemW = mw; NoWrite = nw;
  endtask

  task automatic step(vec_t t);
    @(negedge clk);
    drive(t.valid, t.cond, t.alu, t.flagw, t.pcs, t.regw, t.memw, t.nowr);
    #2;
    chk({t.name, ".CondEx"}, 32'(CondEx), 32'(t.e_cx));
    chk({t.name, ".PCSrc"}, 32'(PCSrc), 32'(t.e_pc));
    chk({t.name, ".RegWrite"}, 32'(RegWrite), 32'(t.e_rw));
    chk({t.name, ".MemWrite"}, 32'(MemWrite), 32'(t.e_mw));
    @(posedge clk);
    #2;
    if (t.valid) begin
      if (t.e_cx) exp_exec = sat(exp_exec);
      else        exp_squash = sat(exp_squash);
    end
    chk({t.name, ".Flags"}, 32'(Flags), 32'(t.e_flags));
    chk_cnt(t.name);
  endtask

  initial begin
    rst_n = 1'b0; perf_clr = 1'b0;
    drive(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    chk("reset.Flags", 32'(Flags), 32'h0);
    chk_cnt("reset");
    @(negedge clk);
    rst_n = 1'b1;

    //             name     v  cond     alu      fw     pc   rw   mw   nw   cx   pc   rw   mw   flags
    vecs.push_back(mk("eq0",  1, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(mk("ne0",  1, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk("al_w", 1, 4'b1110, 4'b0101, 2'b11, 1, 1, 0, 0, 1, 1, 1, 0, 4'b0101));
    vecs.push_back(mk("hi",   1, 4'b1000, 4'b0000, 2'b11, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0101));
    vecs.push_back(mk("ls",   1, 4'b1001, 4'b0000, 2'b00, 0, 0, 1, 0, 1, 0, 0, 1, 4'b0101));
    vecs.push_back(mk("eq_w", 1, 4'b0000, 4'b0000, 2'b11, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk("sq",   1, 4'b0000, 4'b1111, 2'b11, 1, 1, 1, 0, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(mk("nz",   1, 4'b1110, 4'b1110, 2'b10, 0, 1, 0, 1, 1, 0, 0, 0, 4'b0010));
    vecs.push_back(mk("mi_cv",1, 4'b0100, 4'b1100, 2'b01, 0, 1, 0, 0, 1, 0, 1, 0, 4'b1110));
    vecs.push_back(mk("ge",   1, 4'b1010, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1110));
    vecs.push_back(mk("lt",   1, 4'b1011, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1110));
    vecs.push_back(mk("gt",   1, 4'b1100, 4'b0000, 2'b00, 1, 0, 0, 0, 1, 1, 0, 0, 4'b1110));
    vecs.push_back(mk("le",   1, 4'b1101, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1110));
    vecs.push_back(mk("vs",   1, 4'b0110, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1110));
    vecs.push_back(mk("vc",   1, 4'b0111, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1110));
    vecs.push_back(mk("cs",   1, 4'b0010, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1110));
    vecs.push_back(mk("cc",   1, 4'b0011, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1110));
    vecs.push_back(mk("pl",   1, 4'b0101, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1110));
    vecs.push_back(mk("bubl", 0, 4'b1110, 4'b0000, 2'b11, 1, 1, 1, 0, 1, 0, 0, 0, 4'b1110));
    vecs.push_back(mk("nv",   1, 4'b1111, 4'b0000, 2'b01, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0010));
    vecs.push_back(mk("ne1",  1, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0010));
    vecs.push_back(mk("eq1",  1, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010));

    foreach (vecs[i]) step(vecs[i]);

    // perf_clr with a valid instruction: cleared value wins next cycle.
    @(negedge clk);
    drive(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    perf_clr = 1'b1;
    @(posedge clk); #2;
    exp_exec = 0; exp_squash = 0;
    chk_cnt("clr1");
    @(negedge clk);
    perf_clr = 1'b0;

    // 260 valid AL instructions saturate an 8-bit exec counter at 255.
    repeat (260) @(posedge clk);
    #2;
    exp_exec = 255;
    chk_cnt("sat");
    @(posedge clk); #2;
    chk_cnt("sat_hold");

    @(negedge clk);
    perf_clr = 1'b1;
    @(posedge clk); #2;
    exp_exec = 0;
    chk_cnt("clr2");
    @(negedge clk);
    perf_clr = 1'b0;

    // Load Flags=1111, then assert reset during a passing flag write.
    drive(1'b1, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    exp_exec = 1;
    chk("pre_rst.Flags", 32'(Flags), 32'hF);
    @(negedge clk);
    rst_n = 1'b0;
    perf_clr = 1'b0;
    drive(1'b1, 4'b0000, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    // Still evaluated against the stored 1111: EQ passes, strobes follow.
    chk("rst.CondEx_old", 32'(CondEx), 32'h1);
    chk("rst.PCSrc_old", 32'(PCSrc), 32'h1);
    @(posedge clk); #2;
    exp_exec = 0; exp_squash = 0;
    chk("rst.Flags", 32'(Flags), 32'h0);
    chk_cnt("rst");
    chk("rst.CondEx_eq", 32'(CondEx), 32'h0);
    chk("rst.MemWrite", 32'(MemWrite), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'b0001, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    chk("post_rst.ne", 32'(CondEx), 32'h1);
    chk("post_rst.RegWrite", 32'(RegWrite), 32'h1);
    @(posedge clk); #2;
    exp_exec = 1;
    chk_cnt("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
